// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic array datapaths.
// Used by both the input and output datapath blocks.
package systolic_pkg;

    localparam int N      = 4;
    localparam int ELEM_W = 16;
    localparam int BEAT_W = N * ELEM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/output_datapath.sv
// Captures a complete N x N result matrix from the systolic array and
// streams it out one row per beat over a valid/ready interface.
module output_datapath
    import systolic_pkg::state_t;
    import systolic_pkg::IDLE;
    import systolic_pkg::SEND;
    import systolic_pkg::DONE;
#(
    parameter int N      = systolic_pkg::N,
    parameter int ELEM_W = systolic_pkg::ELEM_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N*N*ELEM_W-1:0]   c_in,
    input  logic                    res_valid,
    output logic                    res_ready,
    output logic [N*ELEM_W-1:0]     data_out,
    output logic                    dest_valid,
    input  logic                    dest_ready,
    output logic                    tx_one_done,
    output logic                    unload_done,
    output logic                    busy,
    output logic [1:0]              state_dbg
);

    localparam int BEAT_W = N * ELEM_W;
    localparam int ROW_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    // Handshake: a beat moves on a rising edge only when dest_valid and
    // dest_ready are both high; once raised, dest_valid and data_out hold
    // until that edge. Capture likewise needs res_valid and res_ready.

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [N*N*ELEM_W-1:0]   buf_q;
    logic                    tx_done_q;
    logic                    capture;
    logic                    xfer;
    logic [BEAT_W-1:0]       row_data;

    // Column 0 of the selected row lands in the most significant element.
    always_comb begin
        row_data = '0;
        for (int c = 0; c < N; c++) begin
            row_data[(N-1-c)*ELEM_W +: ELEM_W] =
                buf_q[(int'(row_q)*N + c)*ELEM_W +: ELEM_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        res_ready   = 1'b0;
        dest_valid  = 1'b0;
        unload_done = 1'b0;
        capture     = 1'b0;
        xfer        = 1'b0;
        case (state_q)
            IDLE: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    capture = 1'b1;
                    row_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                dest_valid = 1'b1;
                if (dest_ready) begin
                    xfer = 1'b1;
                    // Hold the counter on the last row so it never wraps in SEND.
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DONE: begin
                unload_done = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            buf_q     <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            tx_done_q <= xfer;
            if (capture) begin
                buf_q <= c_in;
            end
        end
    end

    assign data_out    = dest_valid ? row_data : '0;
    assign tx_one_done = tx_done_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_output_datapath.sv
// Bench for output_datapath: table of result matrices streamed under
// several ready patterns, plus reset corner sequences.
module tb_output_datapath;

    localparam int N      = 4;
    localparam int ELEM_W = 16;
    localparam int MAT_W  = N*N*ELEM_W;
    localparam int BEAT_W = N*ELEM_W;

    typedef struct {
        logic [MAT_W-1:0]  c;
        logic [BEAT_W-1:0] exp_row0;
        logic [BEAT_W-1:0] exp_row1;
        int                stall_row;
        int                stall_len;
        bit                poke;
        bit                rnd;
        bit                has_exp;
    } vec_t;

    logic               clk;
    logic               reset;
    logic [MAT_W-1:0]   c_in;
    logic               res_valid;
    logic               res_ready;
    logic [BEAT_W-1:0]  data_out;
    logic               dest_valid;
    logic               dest_ready;
    logic               tx_one_done;
    logic               unload_done;
    logic               busy;
    logic [1:0]         state_dbg;

    output_datapath #(.N(N), .ELEM_W(ELEM_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .data_out    (data_out),
        .dest_valid  (dest_valid),
        .dest_ready  (dest_ready),
        .tx_one_done (tx_one_done),
        .unload_done (unload_done),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [BEAT_W-1:0] exp_q[$];
    logic [BEAT_W-1:0] beats[N];
    int checks = 0;
    int errors = 0;
    int beat_idx = 0;
    int tx_cnt = 0;
    int ud_cnt = 0;
    int first_cyc = 0;
    int ud_cyc = 0;
    int cap_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [MAT_W-1:0] mk_rcrc();
        logic [MAT_W-1:0] m;
        logic [3:0] r4, c4;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                r4 = 4'(r);
                c4 = 4'(c);
                m[(r*N+c)*ELEM_W +: ELEM_W] = {r4, c4, r4, c4};
            end
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] mk_seq();
        logic [MAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < N*N; i++) m[i*ELEM_W +: ELEM_W] = 16'hA000 + 16'(i);
        return m;
    endfunction

    function automatic logic [BEAT_W-1:0] row_of(input logic [MAT_W-1:0] m, input int r);
        logic [BEAT_W-1:0] row;
        row = '0;
        for (int c = 0; c < N; c++) row = (row << ELEM_W) | BEAT_W'(m[(r*N+c)*ELEM_W +: ELEM_W]);
        return row;
    endfunction

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < MAT_W/32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    // monitor: pops the expected queue on every accepted beat
    bit prev_xfer = 0, prev_last = 0, prev_hold = 0;
    logic [BEAT_W-1:0] hold_data = '0;
    always @(negedge clk) begin
        bit xfer;
        if (!reset) begin
            prev_xfer = 0;
            prev_last = 0;
            prev_hold = 0;
        end else begin
            check("tx_one_done", 64'(tx_one_done), 64'(prev_xfer));
            check("unload_done", 64'(unload_done), 64'(prev_last));
            if (tx_one_done) tx_cnt++;
            if (unload_done) begin
                ud_cnt++;
                ud_cyc = cyc;
            end
            if (prev_hold) begin
                check("hold_valid", 64'(dest_valid), 64'd1);
                check("hold_data", data_out, hold_data);
            end
            xfer = dest_valid && dest_ready;
            prev_last = 0;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", data_out, 64'd0);
                end else begin
                    check("beat_data", data_out, exp_q.pop_front());
                end
                if (beat_idx == 0) first_cyc = cyc;
                beats[beat_idx] = data_out;
                prev_last = (beat_idx == N-1);
                beat_idx = (beat_idx + 1) % N;
            end
            prev_xfer = xfer;
            prev_hold = dest_valid && !dest_ready;
            hold_data = data_out;
        end
    end

    // driver
    task automatic run_matrix(input vec_t v);
        int n, tx0, ud0, stall_left;
        bit done;
        n = 0;
        while (!res_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 64'(n < 50), 64'd1);
        for (int r = 0; r < N; r++) exp_q.push_back(row_of(v.c, r));
        tx0 = tx_cnt;
        ud0 = ud_cnt;
        stall_left = v.stall_len;
        @(negedge clk);
        c_in = v.c;
        res_valid = 1'b1;
        if (v.stall_row == 0 && stall_left > 0) begin
            dest_ready = 1'b0;
            stall_left--;
        end else begin
            dest_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        cap_cyc = cyc;
        n = 0;
        done = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #2;
            n++;
            if (n == 1) begin
                res_valid = 1'b0;
                c_in = rand_mat();
            end
            if (v.poke && n == 2) begin
                res_valid = 1'b1;
                c_in = rand_mat();
                #1 check("res_ready_in_send", 64'(res_ready), 64'd0);
            end
            if (v.poke && n == 3) res_valid = 1'b0;
            if (beat_idx == v.stall_row && stall_left > 0) begin
                dest_ready = 1'b0;
                stall_left--;
            end else begin
                dest_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            done = (ud_cnt != ud0);
        end
        check("matrix_timeout", 64'(done), 64'd1);
        check("tx_per_matrix", 64'(tx_cnt - tx0), 64'(N));
        check("unload_per_matrix", 64'(ud_cnt - ud0), 64'd1);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (v.has_exp) begin
            check("row0_const", beats[0], v.exp_row0);
            check("row1_const", beats[1], v.exp_row1);
        end
        if (!v.rnd && v.stall_len == 0) begin
            check("first_beat_latency", 64'(first_cyc - cap_cyc), 64'd1);
            check("unload_latency", 64'(ud_cyc - cap_cyc), 64'(N+1));
        end
    endtask

    vec_t tbl[4];

    initial begin
        vec_t rv;
        int n, ud0;

        tbl[0] = '{c: mk_rcrc(), exp_row0: 64'h0000_0101_0202_0303, exp_row1: 64'h1010_1111_1212_1313,
                   stall_row: -1, stall_len: 0, poke: 0, rnd: 0, has_exp: 1};
        tbl[1] = '{c: mk_rcrc(), exp_row0: 64'h0000_0101_0202_0303, exp_row1: 64'h1010_1111_1212_1313,
                   stall_row: 1, stall_len: 3, poke: 0, rnd: 0, has_exp: 1};
        tbl[2] = '{c: {MAT_W{1'b1}}, exp_row0: 64'hFFFF_FFFF_FFFF_FFFF, exp_row1: 64'hFFFF_FFFF_FFFF_FFFF,
                   stall_row: -1, stall_len: 0, poke: 1, rnd: 0, has_exp: 1};
        tbl[3] = '{c: mk_seq(), exp_row0: 64'hA000_A001_A002_A003, exp_row1: 64'hA004_A005_A006_A007,
                   stall_row: 2, stall_len: 2, poke: 0, rnd: 0, has_exp: 1};

        // reset held with a matrix offered: nothing may be captured
        reset = 1'b0;
        c_in = mk_rcrc();
        res_valid = 1'b1;
        dest_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res_ready", 64'(res_ready), 64'd1);
        check("rst_dest_valid", 64'(dest_valid), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_tx_one_done", 64'(tx_one_done), 64'd0);
        check("rst_unload_done", 64'(unload_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        res_valid = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 4; i++) run_matrix(tbl[i]);

        for (int i = 0; i < 10; i++) begin
            rv = '{c: rand_mat(), exp_row0: '0, exp_row1: '0,
                   stall_row: -1, stall_len: 0, poke: 0, rnd: 1, has_exp: 0};
            run_matrix(rv);
        end

        // reset after row 1 is accepted aborts the unload
        n = 0;
        while (!res_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int r = 0; r < N; r++) exp_q.push_back(row_of(mk_rcrc(), r));
        ud0 = ud_cnt;
        @(negedge clk);
        c_in = mk_rcrc();
        res_valid = 1'b1;
        dest_ready = 1'b1;
        @(posedge clk);
        #2 res_valid = 1'b0;
        n = 0;
        while (beat_idx < 2 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("abort_reach_row2", 64'(beat_idx), 64'd2);
        dest_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_data_out", data_out, 64'd0);
        check("abort_dest_valid", 64'(dest_valid), 64'd0);
        check("abort_tx_one_done", 64'(tx_one_done), 64'd0);
        check("abort_unload_done", 64'(unload_done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res_ready", 64'(res_ready), 64'd1);
        exp_q.delete();
        beat_idx = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_unload", 64'(ud_cnt - ud0), 64'd0);
        check("abort_idle_ready", 64'(res_ready), 64'd1);
        check("abort_idle_valid", 64'(dest_valid), 64'd0);

        run_matrix(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
